// File: rtl/tsens_pkg.sv
// rtl/tsens_pkg.sv - shared state type and parameter defaults for the sensor readout
package tsens_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RESET = 2'd1,
      ST_INTEG = 2'd2,
      ST_DONE  = 2'd3
   } tsens_state_t;

   localparam int DEF_CNT_W       = 12;
   localparam int DEF_RST_CYC     = 8;
   localparam int DEF_AVG_LOG2    = 2;
   localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/tsens_readout_if.sv
// rtl/tsens_readout_if.sv - result handshake between the readout and the register/scan side
interface tsens_readout_if
   import tsens_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W
);
   logic [CNT_W-1:0] data;
   logic             valid;
   logic             ready;
   logic             overflow;

   modport master (output data, output valid, output overflow, input ready);
   modport slave  (input data, input valid, input overflow, output ready);
endinterface

// File: rtl/sync_ff.sv
// rtl/sync_ff.sv - multi-flop synchronizer for asynchronous analog core outputs
module sync_ff #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_d,
   output logic o_q
);
   logic [STAGES-1:0] r_chain;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_chain <= '0;
      end else begin
         r_chain <= {r_chain[STAGES-2:0], i_d};
      end
   end

   assign o_q = r_chain[STAGES-1];
endmodule

// File: rtl/tsens_readout.sv
// rtl/tsens_readout.sv - integrator reset sequencing, comparator time counting and averaging
module tsens_readout
   import tsens_pkg::*;
#(
   parameter int CNT_W       = DEF_CNT_W,
   parameter int RST_CYC     = DEF_RST_CYC,
   parameter int AVG_LOG2    = DEF_AVG_LOG2,
   parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic              cmp,
   output logic              res_n,
   output logic              busy,
   tsens_readout_if.master   rd
);
   localparam int ACC_W = CNT_W + AVG_LOG2;
   localparam int IDX_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
   localparam int PH_W  = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'((1 << AVG_LOG2) - 1);
   localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(RST_CYC - 1);

   tsens_state_t     r_state;
   logic [PH_W-1:0]  r_phase;
   logic [CNT_W-1:0] r_cnt;
   logic [IDX_W-1:0] r_idx;
   logic [ACC_W-1:0] r_acc;
   logic             r_ovf_acc;
   logic             r_res_n;
   logic             r_busy;
   logic             r_valid;
   logic             r_overflow;
   logic [CNT_W-1:0] r_data;

   logic             w_cmp_s;
   logic             w_final;
   logic [ACC_W-1:0] w_acc_next;

   sync_ff #(
      .STAGES (SYNC_STAGES)
   ) u_cmp_sync (
      .clk   (clk),
      .rst_n (reset_n),
      .i_d   (cmp),
      .o_q   (w_cmp_s)
   );

   // A conversion ends on a comparator trip or when the counter reaches its ceiling
   assign w_final    = w_cmp_s || (r_cnt == CNT_MAX);
   assign w_acc_next = r_acc + ACC_W'(r_cnt);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= ST_IDLE;
         r_phase    <= '0;
         r_cnt      <= '0;
         r_idx      <= '0;
         r_acc      <= '0;
         r_ovf_acc  <= 1'b0;
         r_res_n    <= 1'b0;
         r_busy     <= 1'b0;
         r_valid    <= 1'b0;
         r_overflow <= 1'b0;
         r_data     <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_state   <= ST_RESET;
                  r_busy    <= 1'b1;
                  r_phase   <= '0;
                  r_acc     <= '0;
                  r_idx     <= '0;
                  r_ovf_acc <= 1'b0;
               end
            end
            ST_RESET: begin
               if (r_phase == PH_LAST) begin
                  r_state <= ST_INTEG;
                  r_res_n <= 1'b1;
                  r_cnt   <= '0;
               end else begin
                  r_phase <= r_phase + PH_W'(1);
               end
            end
            ST_INTEG: begin
               if (w_final) begin
                  r_acc   <= w_acc_next;
                  r_res_n <= 1'b0;
                  if (!w_cmp_s) begin
                     r_ovf_acc <= 1'b1;
                  end
                  if (r_idx == IDX_LAST) begin
                     r_state <= ST_DONE;
                  end else begin
                     r_state <= ST_RESET;
                     r_phase <= '0;
                     r_idx   <= r_idx + IDX_W'(1);
                  end
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            ST_DONE: begin
               // First DONE cycle latches the result; ready is only honoured once valid is up
               if (!r_valid) begin
                  r_valid    <= 1'b1;
                  r_data     <= r_acc[ACC_W-1:AVG_LOG2];
                  r_overflow <= r_ovf_acc;
               end else if (rd.ready) begin
                  r_valid <= 1'b0;
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign res_n       = r_res_n;
   assign busy        = r_busy;
   assign rd.data     = r_data;
   assign rd.valid    = r_valid;
   assign rd.overflow = r_overflow;
endmodule

// File: tb/tb_tsens_readout.sv
// tb/tb_tsens_readout.sv - timeline-model bench over three readout configurations
module tb_tsens_readout;
   localparam int NU = 3;
   localparam int R_OF   [NU] = '{8, 8, 3};
   localparam int AVG_OF [NU] = '{0, 2, 0};
   localparam int S_OF   [NU] = '{2, 2, 3};
   localparam int MX_OF  [NU] = '{4095, 4095, 63};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rstn      [NU];
   logic        start_v   [NU];
   logic        cmp_v     [NU];
   logic        rdy_v     [NU];
   logic        obs_res_n [NU];
   logic        obs_busy  [NU];
   logic        obs_valid [NU];
   logic        obs_ovf   [NU];
   logic [11:0] obs_data  [NU];

   logic        e_res_n [NU];
   logic        e_busy  [NU];
   logic        e_valid [NU];
   logic        e_ovf   [NU];
   logic [11:0] e_data  [NU];

   int n_checks = 0;
   int n_errors = 0;
   bit cmp_en   = 1'b0;

   tsens_readout_if #(.CNT_W(12)) if0 ();
   tsens_readout_if #(.CNT_W(12)) if1 ();
   tsens_readout_if #(.CNT_W(6))  if2 ();

   assign if0.ready = rdy_v[0];
   assign if1.ready = rdy_v[1];
   assign if2.ready = rdy_v[2];
   assign obs_data[0]  = if0.data;
   assign obs_data[1]  = if1.data;
   assign obs_data[2]  = {6'd0, if2.data};
   assign obs_valid[0] = if0.valid;
   assign obs_valid[1] = if1.valid;
   assign obs_valid[2] = if2.valid;
   assign obs_ovf[0]   = if0.overflow;
   assign obs_ovf[1]   = if1.overflow;
   assign obs_ovf[2]   = if2.overflow;

   tsens_readout #(.CNT_W(12), .RST_CYC(8), .AVG_LOG2(0), .SYNC_STAGES(2)) dut0 (
      .clk(clk), .reset_n(rstn[0]), .start(start_v[0]), .cmp(cmp_v[0]),
      .res_n(obs_res_n[0]), .busy(obs_busy[0]), .rd(if0));
   tsens_readout #(.CNT_W(12), .RST_CYC(8), .AVG_LOG2(2), .SYNC_STAGES(2)) dut1 (
      .clk(clk), .reset_n(rstn[1]), .start(start_v[1]), .cmp(cmp_v[1]),
      .res_n(obs_res_n[1]), .busy(obs_busy[1]), .rd(if1));
   tsens_readout #(.CNT_W(6), .RST_CYC(3), .AVG_LOG2(0), .SYNC_STAGES(3)) dut2 (
      .clk(clk), .reset_n(rstn[2]), .start(start_v[2]), .cmp(cmp_v[2]),
      .res_n(obs_res_n[2]), .busy(obs_busy[2]), .rd(if2));

   task automatic check(input string name, input int u, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s u%0d t=%0t actual=%0d required=%0d", name, u, $time, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_idle(input int u);
      e_res_n[u] = 1'b0;
      e_busy[u]  = 1'b0;
      e_valid[u] = 1'b0;
   endtask

   always @(negedge clk) begin
      if (cmp_en) begin
         for (int u = 0; u < NU; u++) begin
            check("res_n", u, 32'(obs_res_n[u]), 32'(e_res_n[u]));
            check("busy",  u, 32'(obs_busy[u]),  32'(e_busy[u]));
            check("valid", u, 32'(obs_valid[u]), 32'(e_valid[u]));
            if (e_valid[u]) begin
               check("data",     u, 32'(obs_data[u]), 32'(e_data[u]));
               check("overflow", u, 32'(obs_ovf[u]),  32'(e_ovf[u]));
            end
         end
      end
   end

   // Cycle 0 drives start; the measurement schedule is worked out as plain interval arithmetic
   task automatic run_txn(input int u, input int n0, input int n1, input int n2, input int n3,
                          input bit hi, input int dready, input bit noise, input int rst_samp,
                          output logic [11:0] got_d, output logic got_o);
      int nn [4];
      int rise [4];
      int tr [4];
      int ns, t, s, sum, big_t, last, rst_c;
      bit ov, in_int, hi_c;
      nn[0] = n0; nn[1] = n1; nn[2] = n2; nn[3] = n3;
      ns  = 1 << AVG_OF[u];
      t   = 1;
      sum = 0;
      ov  = 1'b0;
      for (int i = 0; i < ns; i++) begin
         rise[i] = t + R_OF[u];
         if (hi) s = 0;
         else if (nn[i] + S_OF[u] > MX_OF[u]) begin s = MX_OF[u]; ov = 1'b1; end
         else s = nn[i] + S_OF[u];
         tr[i] = rise[i] + s + 1;
         t   = tr[i];
         sum += s;
      end
      big_t = t;
      last  = big_t + 1 + dready;
      rst_c = (rst_samp >= 0) ? rise[rst_samp] + 2 : -1000;
      got_d = '0;
      got_o = 1'b0;
      for (int c = -4; c <= last + 2; c++) begin
         step();
         in_int = 1'b0;
         hi_c   = 1'b0;
         for (int i = 0; i < ns; i++) begin
            if (c >= rise[i] && c < tr[i]) in_int = 1'b1;
            if (c >= rise[i] + nn[i] && c < tr[i]) hi_c = 1'b1;
         end
         start_v[u] = (c == 0) || (noise && c >= 1 && c <= last && $urandom_range(0, 3) == 0);
         rdy_v[u]   = (c <= big_t) ? (noise && $urandom_range(0, 1) == 1) : (c == last);
         cmp_v[u]   = hi || hi_c;
         e_busy[u]  = (c >= 1 && c <= last);
         e_res_n[u] = in_int;
         e_valid[u] = (c >= big_t + 1 && c <= last);
         e_data[u]  = 12'(sum >> AVG_OF[u]);
         e_ovf[u]   = ov;
         if (c == last) begin
            got_d = obs_data[u];
            got_o = obs_ovf[u];
         end
         if (c == rst_c) begin
            #2;
            rstn[u] = 1'b0;
            set_idle(u);
            start_v[u] = 1'b0;
            rdy_v[u]   = 1'b0;
            cmp_v[u]   = 1'b0;
            #1;
            check("mid_rst_res_n", u, 32'(obs_res_n[u]), 0);
            check("mid_rst_busy",  u, 32'(obs_busy[u]),  0);
            check("mid_rst_valid", u, 32'(obs_valid[u]), 0);
            check("mid_rst_data",  u, 32'(obs_data[u]),  0);
            check("mid_rst_ovf",   u, 32'(obs_ovf[u]),   0);
            step();
            rstn[u] = 1'b1;
            step();
            return;
         end
      end
      start_v[u] = 1'b0;
      rdy_v[u]   = 1'b0;
      cmp_v[u]   = 1'b0;
      set_idle(u);
   endtask

   initial begin
      logic [11:0] d;
      logic        o;
      int          u, lim;
      for (int i = 0; i < NU; i++) begin
         rstn[i] = 1'b0; start_v[i] = 1'b0; cmp_v[i] = 1'b0; rdy_v[i] = 1'b0;
         set_idle(i);
         e_data[i] = '0;
         e_ovf[i]  = 1'b0;
      end
      repeat (3) step();
      for (int i = 0; i < NU; i++) begin
         check("rst_res_n", i, 32'(obs_res_n[i]), 0);
         check("rst_busy",  i, 32'(obs_busy[i]),  0);
         check("rst_valid", i, 32'(obs_valid[i]), 0);
         check("rst_data",  i, 32'(obs_data[i]),  0);
         check("rst_ovf",   i, 32'(obs_ovf[i]),   0);
      end
      cmp_en = 1'b1;
      for (int i = 0; i < NU; i++) rstn[i] = 1'b1;
      repeat (2) step();

      run_txn(0, 20, 0, 0, 0, 1'b0, 0, 1'b0, -1, d, o);
      check("single_data", 0, 32'(d), 22);
      check("single_ovf",  0, 32'(o), 0);

      run_txn(1, 8, 8, 8, 9, 1'b0, 2, 1'b0, -1, d, o);
      check("avg_data", 1, 32'(d), 10);

      run_txn(2, 1000, 0, 0, 0, 1'b0, 1, 1'b0, -1, d, o);
      check("timeout_data", 2, 32'(d), 63);
      check("timeout_ovf",  2, 32'(o), 1);

      run_txn(1, 3, 4, 5, 6, 1'b0, 50, 1'b1, -1, d, o);
      check("backpress_data", 1, 32'(d), 6);

      run_txn(1, 30, 30, 30, 30, 1'b0, 0, 1'b1, 2, d, o);
      run_txn(1, 5, 6, 7, 8, 1'b0, 1, 1'b1, -1, d, o);
      check("post_rst_data", 1, 32'(d), 8);
      check("post_rst_ovf",  1, 32'(o), 0);

      run_txn(1, 0, 0, 0, 0, 1'b1, 0, 1'b1, -1, d, o);
      check("early_data", 1, 32'(d), 0);
      check("early_ovf",  1, 32'(o), 0);

      for (int k = 0; k < 12; k++) begin
         u   = k % NU;
         lim = (u == 2) ? 70 : 40;
         run_txn(u, $urandom_range(0, lim), $urandom_range(0, lim), $urandom_range(0, lim),
                 $urandom_range(0, lim), ($urandom_range(0, 5) == 0), $urandom_range(0, 6),
                 1'b1, -1, d, o);
      end

      repeat (3) step();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
